// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg: shared constants and FSM encoding for the nibble-serial subtractor
package nibble_sub_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nibble_cla4.sv
// nibble_cla4: purely combinational 4-bit carry-lookahead adder slice
module nibble_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ c[3:0];
    cout = c[4];
    c3   = c[3];
  end
endmodule

// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: nibble-serial W-bit subtractor (a - b - bin) with valid/ready handshake; SUB_OVF_EN adds signed-overflow port ovf
module nibble_sub_seq
  import nibble_sub_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bout
`ifdef SUB_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic carry, accept, step, last;
  logic [NIBBLE_W-1:0] op_a, op_b, s;
  logic cout, c3;
  always_comb begin
    accept    = (state == IDLE) && in_valid;
    step      = (state == RUN);
    last      = (cnt == CW'(NIBBLES - 1));
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    op_a      = a_r[cnt*NIBBLE_W +: NIBBLE_W];
    op_b      = ~b_r[cnt*NIBBLE_W +: NIBBLE_W];
    state_n   = accept                           ? RUN  :
                (step && last)                   ? DONE :
                ((state == DONE) && out_ready)   ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // subtraction as a + ~b + ~bin: the carry register starts at ~bin and borrow is the inverted final carry
  nibble_cla4 u_cla (
    .a   (op_a),
    .b   (op_b),
    .c0  (carry),
    .s   (s),
    .cout(cout),
    .c3  (c3)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      cnt   <= '0;
      carry <= ~bin;
    end else if (step) begin
      d[cnt*NIBBLE_W +: NIBBLE_W] <= s;
      carry <= cout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        bout <= ~cout;
`ifdef SUB_OVF_EN
        ovf  <= c3 ^ cout;
`endif
      end
    end
`ifndef SUB_OVF_EN
  logic unused_c3;
  assign unused_c3 = c3;
`endif
endmodule

// File: tb/tb_nibble_sub_seq.sv
// tb_nibble_sub_seq: scoreboard bench for nibble_sub_seq (NIBBLES=4); checks ovf when built with SUB_OVF_EN
module tb_nibble_sub_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, bout;
  logic [W-1:0] d;
`ifdef SUB_OVF_EN
  logic ovf;
`endif
  int total = 0, bad = 0, cyc = 0, acc_cyc = -1, last_acc = -1, n_sp = 0;
  bit b2b = 0;
  logic prev_ov = 1'b0;
  logic [W+1:0] exp_q[$];

  nibble_sub_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: accept timing, output latency and result scoreboard
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        if (b2b && last_acc >= 0) begin
          chk("accept_spacing", cyc + 1 - last_acc, N + 2);
          n_sp++;
        end
        last_acc = cyc + 1;
        acc_cyc  = cyc + 1;
      end
      if (out_valid && !prev_ov && acc_cyc >= 0) chk("latency", cyc - acc_cyc, N);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got d=%0h expected none", d);
        end else begin
          e = exp_q.pop_front();
          chk("d", d, e[W+1:2]);
          chk("bout", bout, e[1]);
`ifdef SUB_OVF_EN
          chk("ovf", ovf, e[0]);
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       input bit push, input logic [W-1:0] ed, input logic eb, input logic eo);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    if (push) exp_q.push_back({ed, eb, eo});
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  logic [W-1:0] bv_a [4] = '{16'h0001, 16'hABCD, 16'h8000, 16'h4000};
  logic [W-1:0] bv_b [4] = '{16'h0002, 16'h1234, 16'h8000, 16'hC000};
  logic         bv_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] bv_d [4] = '{16'hFFFF, 16'h9999, 16'hFFFF, 16'h8000};
  logic         bv_bo[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic         bv_ov[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_d", d, 0);
    chk("reset_bout", bout, 0);
`ifdef SUB_OVF_EN
    chk("reset_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    issue(16'h1234, 16'h0234, 1'b0, 1, 16'h1000, 1'b0, 1'b0);
    issue(16'h0000, 16'h0001, 1'b0, 1, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1, 16'h7FFF, 1'b0, 1'b1);
    issue(16'h0005, 16'h0005, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1, 16'h8000, 1'b1, 1'b1);
    drain();
    // stall in DONE with in_valid pulses that must be ignored
    out_ready = 1'b0;
    issue(16'h00A5, 16'h0013, 1'b0, 1, 16'h0092, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = ~i[0];
      a = 16'hDEAD;
      b = 16'h0001;
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_d", d, 16'h0092);
      chk("stall_bout", bout, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    @(posedge clk); #1;
    // abort during RUN after two nibbles
    issue(16'h1111, 16'h0001, 1'b0, 0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_d", d, 0);
    @(posedge clk); #1;
    issue(16'h00FF, 16'h0010, 1'b0, 1, 16'h00EF, 1'b0, 1'b0);
    drain();
    // back-to-back with in_valid and out_ready held high
    b2b = 1;
    last_acc = -1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = bv_a[i]; b = bv_b[i]; bin = bv_c[i];
      exp_q.push_back({bv_d[i], bv_bo[i], bv_ov[i]});
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("spacing_checks", n_sp, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
